uart_io_tx: RTL
===============

Name: uart_io_tx

Overview:
- Memory-mapped I/O responder on the processor's store-side I/O strobe; it is the receiving end of io_rw stores to the I/O word at 0xFFFFFFFC.
- Each byte stored there is queued in a small FIFO and serialised out as UART 8N1.
- A combinational status word is provided for the top-level load-data mux, so software can poll busy/full state.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous reset, active-high.
- io_rw  in  1  store strobe to I/O word, sampled at rising clk.
- io_wdata  in  32  store data (rs2); [7:0] byte, [8] control flag.
- io_status  out  32  combinational status word for load mux.
- uart_tx  out  1  serial output line, idle high.

Behaviour:
- Reset (async, active-high): FIFO emptied, overflow cleared, FSM to IDLE, uart_tx=1 immediately. io_status then reads 0x00000002 (empty only).
- Write decode on an edge with io_rw=1:
  - io_wdata[8]=1: control write; clears overflow; nothing pushed.
  - io_wdata[8]=0: push io_wdata[7:0].
- Push is accepted if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the byte is dropped and sticky overflow is set.
- One push maximum per cycle. io_rw held high N cycles gives N pushes; a processor stall repeating a store is the caller's concern.
- io_status fields:
  - [0] busy: FSM != IDLE.
  - [1] empty.
  - [2] full.
  - [3] overflow.
  - [15:8] count, zero-extended.
  - All other bits 0.
  - Combinational from registered state; reflects the pre-edge value in the cycle of a push.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO non-empty, pop head into shift register, clear bit counter and baud counter, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: uart_tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After 8 bits, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles from START entry.
  - Back-to-back frames are separated by exactly one IDLE cycle (the pop cycle).
  - Latency from the push edge to the uart_tx falling edge, FIFO empty and IDLE: 2 edges (push, then pop/START entry).
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit counter is 3 bits.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Boundary cases:
  - Full FIFO with simultaneous pop: push accepted, count unchanged.
  - Empty FIFO with simultaneous push: no pop that edge, since pop requires pre-edge non-empty.
  - Overflow write and clear in different cycles: the later event wins. A clear on the same edge as an overflowing push leaves overflow=1 (set has priority).
  - Reset mid-frame: frame aborted, line returns high asynchronously, no partial resume.
- uart_tx is registered; there are no glitches between states.

Decomposition:
- Package uart_io_pkg:
  - FSM state enum (IDLE/START/DATA/STOP).
  - Status bit positions (ST_BUSY=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3, ST_COUNT_LSB=8).
  - IO_ADDR=32'hFFFFFFFC.
  - CTRL_CLR_BIT=8.
- Sub-module sync_fifo (parameterised width/depth):
  - push/pop/full/empty/count, registered storage.
  - Read head visible combinationally.
  - Async active-high reset.
- The top holds the FSM, baud/bit counters, shift register, overflow flag and status assembly.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Reset, idle 20 cycles -> uart_tx=1 throughout, io_status=0x00000002.
- Single store 0x000000A5 -> START low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then STOP high 4 cycles. Busy=1 for exactly 40 cycles. Status returns to 0x00000002.
- Nine stores 0x01..0x09 on consecutive cycles -> first popped at second edge, remaining eight fill the FIFO (full=1, count=8 after the ninth). Frames are 0x01..0x09 in order, each separated by exactly one idle-high cycle.
- Fill FIFO while the first frame is mid-flight, then one more store 0x55 -> dropped, overflow=1, 0x55 never transmitted. Store 0x00000100 -> overflow=0, count unchanged.
- Push on the exact edge where IDLE pops with the FIFO full -> count stays 8, no overflow, pushed byte transmitted last.
- Assert reset during DATA bit 3 of 0xFF -> uart_tx=1 within the same cycle (asynchronous). After release, status=0x00000002 and no residual frame is emitted.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// status word layout and the I/O decode constants.
package uart_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BYTE_W       = 8;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_FULL      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam logic [DATA_W-1:0] IO_ADDR = 32'hFFFF_FFFC;
  localparam int unsigned CTRL_CLR_BIT  = 8;

endpackage

// File: rtl/uart_io_tx_if.sv
// Store-side I/O strobe and status word between the processor and the UART.
interface uart_io_tx_if;
  import uart_io_pkg::*;

  logic              io_rw;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_status;

  modport master (output io_rw, output io_wdata, input io_status);
  modport slave  (input io_rw, input io_wdata, output io_status);

endinterface

// File: rtl/uart_io_tx_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinationally visible head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign head  = mem[rptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/uart_io_tx.sv
// I/O-mapped UART 8N1 transmitter: stores to the I/O word are queued in a
// FIFO and serialised; a combinational status word feeds the load mux.
module uart_io_tx
  import uart_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  uart_io_tx_if.slave  io,
  output logic         uart_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q;

  logic              wr_byte, wr_ctrl, push, pop, ovf_set;
  logic              full, empty, baud_end;
  logic [CW-1:0]     count;
  logic [BYTE_W-1:0] head;
  logic              unused_wdata_hi;

  assign wr_ctrl  = io.io_rw &&  io.io_wdata[CTRL_CLR_BIT];
  assign wr_byte  = io.io_rw && !io.io_wdata[CTRL_CLR_BIT];
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push     = wr_byte && (!full || pop);
  assign ovf_set  = wr_byte && full && !pop;
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign unused_wdata_hi = ^io.io_wdata[DATA_W-1:CTRL_CLR_BIT+1];

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (io.io_wdata[BYTE_W-1:0]),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Set wins over a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (wr_ctrl) ovf_q <= 1'b0;
  end

  // tx_d is the line level for the state being entered, keeping uart_tx registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    io.io_status                         = '0;
    io.io_status[ST_BUSY]                = (state_q != IDLE);
    io.io_status[ST_EMPTY]               = empty;
    io.io_status[ST_FULL]                = full;
    io.io_status[ST_OVF]                 = ovf_q;
    io.io_status[ST_COUNT_LSB +: CW]     = count;
  end

  assign uart_tx = tx_q;

endmodule
